// File: rtl/instr_align_buffer.sv
// Instruction fetch/alignment buffer: word-aligned fetches in, one RVC or 32-bit
// instruction per handshake out, with stale-response dropping on redirect.
module instr_align_buffer #(
    parameter int unsigned                ADDR_WIDTH = 32,
    parameter int unsigned                DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  req_valid_o,
    output logic [ADDR_WIDTH-1:0] req_addr_o,
    input  logic                  req_ready_i,
    input  logic                  resp_valid_i,
    input  logic [31:0]           resp_data_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           out_instr_o,
    output logic [ADDR_WIDTH-1:0] out_pc_o,
    output logic                  out_is16_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = CW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [15:0] half;
        logic        is16;
        logic        need2;
    } align_t;

    logic [DEPTH-1:0][31:0]  mem_q;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]           count_q, count_d, outst_q, outst_d, drop_q, drop_d;
    logic [ADDR_WIDTH-1:0]   head_pc_q, head_pc_d, fetch_pc_q, fetch_pc_d;

    logic [31:0]             w0;
    logic [15:0]             w1_lo;
    align_t                  al;
    logic                    avail, resp_ok, push, pop, req_fire, out_fire;
    logic [OW-1:0]           occ;

    assign w0    = mem_q[rd_ptr_q];
    assign w1_lo = mem_q[rd_ptr_q + PW'(1)][15:0];

    always_comb begin
        al.half  = head_pc_q[1] ? w0[31:16] : w0[15:0];
        al.is16  = (al.half[1:0] != 2'b11);
        al.need2 = ~al.is16 & head_pc_q[1];
    end

    assign avail = al.need2 ? (count_q >= CW'(2)) : (count_q != '0);

    // Redirect and reset both mask the handshakes combinationally so the
    // neighbours never see a transfer that the state update will discard.
    assign occ         = OW'(count_q) + OW'(outst_q);
    assign req_valid_o = (occ < OW'(DEPTH)) & ~redirect_valid_i & ~rst_i;
    assign req_addr_o  = fetch_pc_q;
    assign out_valid_o = avail & ~redirect_valid_i & ~rst_i;
    assign out_pc_o    = head_pc_q;
    assign out_is16_o  = out_valid_o & al.is16;

    always_comb begin
        out_instr_o = NOP;
        if (out_valid_o) begin
            if (al.is16)           out_instr_o = {16'h0000, al.half};
            else if (head_pc_q[1]) out_instr_o = {w1_lo, w0[31:16]};
            else                   out_instr_o = w0;
        end
    end

    assign req_fire = req_valid_o & req_ready_i;
    assign resp_ok  = resp_valid_i & (outst_q != '0);
    assign push     = resp_ok & (drop_q == '0);
    assign out_fire = out_valid_o & out_ready_i;
    // A word leaves the queue once the head crosses its upper halfword.
    assign pop      = out_fire & (head_pc_q[1] | ~al.is16);

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        head_pc_d  = head_pc_q;
        fetch_pc_d = fetch_pc_q;
        if (resp_ok) begin
            outst_d = outst_q - CW'(1);
            if (drop_q != '0) drop_d = drop_q - CW'(1);
        end
        if (redirect_valid_i) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            drop_d     = outst_d;
            head_pc_d  = redirect_pc_i & ~ADDR_WIDTH'(1);
            fetch_pc_d = redirect_pc_i & ~ADDR_WIDTH'(3);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
                outst_d    = outst_d + CW'(1);
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (out_fire) head_pc_d = head_pc_q + (al.is16 ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            head_pc_q  <= RESET_PC;
            fetch_pc_q <= RESET_PC & ~ADDR_WIDTH'(3);
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            head_pc_q  <= head_pc_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Queue storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (push && !redirect_valid_i) mem_q[wr_ptr_q] <= resp_data_i;
    end

endmodule

// File: tb/tb_instr_align_buffer.sv
// Directed bench for instr_align_buffer: behavioural memory with per-address
// latency, output monitor, and hand-computed expected instruction streams.
module tb_instr_align_buffer;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic        req_ready_i = 1'b1;
    logic        resp_valid_i = 1'b0;
    logic [31:0] resp_data_i = '0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        out_is16_o;

    instr_align_buffer #(.ADDR_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
        .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_instr_o(out_instr_o), .out_pc_o(out_pc_o), .out_is16_o(out_is16_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] addr; int rdy; } pend_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; logic is16; int cyc; } obs_t;

    logic [31:0] mem [logic [31:0]];
    pend_t       pend[$];
    obs_t        obs[$];
    logic [31:0] acc[$];
    int          cyc = 0;
    int          base_dly = 0;
    logic [31:0] slow_addr = 32'hFFFF_FFF0;
    int          slow_dly = 0;
    int          resp4_cyc = -1;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Memory: decides at the falling edge what the next rising edge samples.
    initial begin
        forever begin
            @(negedge clk_i);
            resp_valid_i = 1'b0;
            if (rst_i) begin
                pend.delete();
            end else begin
                if (pend.size() > 0 && pend[0].rdy <= cyc) begin
                    resp_valid_i = 1'b1;
                    resp_data_i  = mem_rd(pend[0].addr);
                    if (pend[0].addr == 32'h4) resp4_cyc = cyc;
                    void'(pend.pop_front());
                end
                if (req_valid_o && req_ready_i) begin
                    pend.push_back('{addr: req_addr_o,
                                     rdy: cyc + 1 + base_dly + ((req_addr_o == slow_addr) ? slow_dly : 0)});
                    acc.push_back(req_addr_o);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i && out_valid_o && out_ready_i)
                obs.push_back('{pc: out_pc_o, ins: out_instr_o, is16: out_is16_o, cyc: cyc});
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        redirect_valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        obs.delete();
        acc.delete();
        resp4_cyc = -1;
        rst_i = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                              input logic is16, output int c);
        obs_t o;
        c = -1;
        for (int i = 0; i < 200 && obs.size() == 0; i++) @(posedge clk_i);
        chk({tag, ".avail"}, 32'(obs.size() != 0), 32'd1);
        if (obs.size() != 0) begin
            o = obs.pop_front();
            c = o.cyc;
            chk({tag, ".pc"},   o.pc,          pc);
            chk({tag, ".ins"},  o.ins,         ins);
            chk({tag, ".is16"}, 32'(o.is16),   32'(is16));
        end
    endtask

    task automatic wait_acc(input string tag, input int n);
        for (int i = 0; i < 200 && acc.size() < n; i++) @(posedge clk_i);
        chk({tag, ".acc"}, 32'(acc.size() >= n), 32'd1);
    endtask

    initial begin
        int c, c2;
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.req_valid", 32'(req_valid_o), 32'd0);
        chk("rst.out_valid", 32'(out_valid_o), 32'd0);
        chk("rst.out_instr", out_instr_o,      32'h0000_0013);
        chk("rst.out_pc",    out_pc_o,         32'h0);
        chk("rst.out_is16",  32'(out_is16_o),  32'd0);

        // Plain 32-bit stream
        mem.delete();
        mem[32'h0] = 32'h0000_0013;
        mem[32'h4] = 32'h00A0_0093;
        out_ready_i = 1'b1;
        do_reset();
        #1;
        chk("first.req_valid", 32'(req_valid_o), 32'd1);
        chk("first.req_addr",  req_addr_o,        32'h0);
        expect_out("seq0", 32'h0, 32'h0000_0013, 1'b0, c);
        expect_out("seq1", 32'h4, 32'h00A0_0093, 1'b0, c);

        // Mixed RVC, halfword-aligned 32-bit instruction spanning two words
        mem.delete();
        mem[32'h0] = 32'h0093_4505;
        mem[32'h4] = 32'h4501_00A0;
        do_reset();
        expect_out("rvc0", 32'h0, 32'h0000_4505, 1'b1, c);
        expect_out("rvc1", 32'h2, 32'h00A0_0093, 1'b0, c);
        expect_out("rvc2", 32'h6, 32'h0000_4501, 1'b1, c);
        expect_out("rvc3", 32'h8, 32'h0000_0013, 1'b0, c);

        // Spanning instruction waits for a slow second word
        slow_addr = 32'h4;
        slow_dly  = 5;
        do_reset();
        expect_out("span0", 32'h0, 32'h0000_4505, 1'b1, c);
        expect_out("span1", 32'h2, 32'h00A0_0093, 1'b0, c2);
        chk("span.lat", 32'(c2 - resp4_cyc), 32'd1);
        slow_dly  = 0;
        slow_addr = 32'hFFFF_FFF0;

        // Backpressure: queue fills to DEPTH, fetch stalls, then drains in order
        mem.delete();
        mem[32'h0] = 32'h0010_0093;
        mem[32'h4] = 32'h0020_0113;
        mem[32'h8] = 32'h0030_0193;
        mem[32'hC] = 32'h0040_0213;
        out_ready_i = 1'b0;
        do_reset();
        repeat (10) @(posedge clk_i);
        #1;
        chk("bp.nacc",      32'(acc.size()),  32'd4);
        chk("bp.req_valid", 32'(req_valid_o), 32'd0);
        chk("bp.out_valid", 32'(out_valid_o), 32'd1);
        for (int i = 0; i < 4 && i < acc.size(); i++) chk("bp.addr", acc[i], 32'(i * 4));
        out_ready_i = 1'b1;
        expect_out("bp0", 32'h0, 32'h0010_0093, 1'b0, c);
        expect_out("bp1", 32'h4, 32'h0020_0113, 1'b0, c);
        expect_out("bp2", 32'h8, 32'h0030_0193, 1'b0, c);
        expect_out("bp3", 32'hC, 32'h0040_0213, 1'b0, c);
        wait_acc("bp.resume", 5);
        if (acc.size() >= 5) chk("bp.resume_addr", acc[4], 32'h10);

        // Redirect with two stale fetches in flight
        mem.delete();
        mem[32'h0]   = 32'h1111_1113;
        mem[32'h4]   = 32'h2222_2223;
        mem[32'h100] = 32'h4509_0000;
        mem[32'h104] = 32'h0050_0293;
        base_dly = 4;
        req_ready_i = 1'b0;
        do_reset();
        req_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        req_ready_i = 1'b0;
        base_dly = 0;
        chk("rd.inflight", 32'(acc.size()), 32'd2);
        redirect_valid_i = 1'b1;
        redirect_pc_i    = 32'h0000_0103;
        #1;
        chk("rd.req_valid", 32'(req_valid_o), 32'd0);
        chk("rd.out_valid", 32'(out_valid_o), 32'd0);
        @(posedge clk_i);
        #1;
        redirect_valid_i = 1'b0;
        req_ready_i = 1'b1;
        wait_acc("rd.new", 3);
        if (acc.size() >= 3) chk("rd.new_addr", acc[2], 32'h100);
        expect_out("rd0", 32'h102, 32'h0000_4509, 1'b1, c);
        expect_out("rd1", 32'h104, 32'h0050_0293, 1'b0, c);

        // Asynchronous reset in the middle of three outstanding fetches
        mem.delete();
        mem[32'h0] = 32'h0070_0393;
        base_dly = 5;
        do_reset();
        wait_acc("ar.fill", 3);
        #3;
        rst_i = 1'b1;
        #1;
        chk("ar.req_valid", 32'(req_valid_o), 32'd0);
        chk("ar.out_valid", 32'(out_valid_o), 32'd0);
        chk("ar.out_instr", out_instr_o,      32'h0000_0013);
        base_dly = 0;
        do_reset();
        wait_acc("ar.restart", 1);
        if (acc.size() >= 1) chk("ar.addr", acc[0], 32'h0);
        expect_out("ar0", 32'h0, 32'h0070_0393, 1'b0, c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_align_buffer.md
# instr_align_buffer

Instruction fetch/alignment buffer sitting between the instruction memory port and the IF/ID pipe register of the five-stage core. Issues word-aligned fetch requests, queues returned 32-bit words, and presents one instruction per handshake (16-bit RVC or 32-bit, at any halfword-aligned PC) with its PC and size flag. It discards stale fetch data on branch/exception redirect, so stalls and redirects never have to be handled on the memory side.

## Interface
- ADDR_WIDTH, 32, PC/address width
- DEPTH, 4, queue capacity in 32-bit words; power of two, >= 2
- RESET_PC, 32'h0000_0000, first instruction PC after reset; bit 0 must be 0
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  out  1  fetch request valid
- req_addr  out  ADDR_WIDTH  word-aligned fetch address (bits[1:0]=0)
- req_ready  in  1  memory accepts request
- resp_valid  in  1  fetch data returned, in request order, >= 1 cycle after acceptance
- resp_data  in  32  fetched word, little-endian
- redirect_valid  in  1  branch/exception redirect (one-cycle pulse)
- redirect_pc  in  ADDR_WIDTH  new PC; bit 0 ignored (treated as 0)
- out_valid  out  1  instruction available
- out_ready  in  1  IF/ID accepts (low when IF/ID stalled)
- out_instr  out  32  instruction; 16-bit forms zero-extended; 32'h0000_0013 when out_valid=0
- out_pc  out  ADDR_WIDTH  PC of out_instr
- out_is16  out  1  out_instr is compressed

## Operation
- State: word queue (DEPTH entries, rd/wr pointers, count 0..DEPTH), head_pc, fetch_pc, outstanding counter (0..DEPTH), drop counter (0..DEPTH).
- Fetch: req_valid = (count + outstanding < DEPTH) & ~redirect_valid; req_addr = fetch_pc. On req_valid & req_ready: fetch_pc += 4, outstanding += 1.
- Response: on resp_valid, outstanding -= 1; if drop > 0 then drop -= 1 and data discarded, else word pushed at wr pointer. resp_valid with outstanding = 0 is a protocol error and is ignored (no state change).
- Alignment, head word W0, next word W1: halfword h = head_pc[1] ? W0[31:16] : W0[15:0]; is16 = (h[1:0] != 2'b11).
  - is16: needs W0; out_instr = {16'h0, h}.
  - 32-bit, head_pc[1]=0: needs W0; out_instr = W0.
  - 32-bit, head_pc[1]=1: needs W0 and W1; out_instr = {W1[15:0], W0[31:16]}.
- out_valid = required words present (count >= 1 or >= 2) & ~redirect_valid.
- Consume on out_valid & out_ready: head_pc += is16 ? 2 : 4; pop one word iff (head_pc[1] + (is16 ? 1 : 2)) >= 2, otherwise no pop. Never pops more than one word.
- Push and pop in the same cycle allowed at any count, including full.
- Redirect (highest priority): queue emptied (count=0, pointers reset), head_pc <= {redirect_pc[ADDR_WIDTH-1:1],1'b0}, fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}, drop <= outstanding after this cycle's response decrement (redirect forces req_valid=0, so no acceptance that cycle); out handshake that cycle ignored.
- Width rules: PC arithmetic wraps modulo 2^ADDR_WIDTH; counters saturate-free by construction (count + outstanding <= DEPTH invariant).

## Timing
- Reset (async assert, sync-safe release): count=outstanding=drop=0, head_pc=RESET_PC, fetch_pc=RESET_PC & ~3; req_valid=0 and out_valid=0 while rst high; out_instr=32'h13, out_pc=RESET_PC, out_is16=0.
- First req_valid in first cycle after rst deasserts.
- Pushed word visible to alignment logic the cycle after resp_valid (no bypass): resp at cycle N -> out_valid earliest N+1.
- Redirect at cycle R: out_valid and req_valid 0 in R; first request to new address in R+1; stale responses arriving R..later dropped until drop=0.
- Steady state with 1-cycle memory and out_ready=1: one instruction per cycle for 32-bit code, no bubbles.

## Test plan
- Reset RESET_PC=0, mem[0]=32'h0000_0013, mem[4]=32'h00A0_0093, out_ready=1 -> outputs (pc 0x0, 0x00000013, is16=0), then (pc 0x4, 0x00A00093, is16=0).
- Mixed RVC: mem[0]=32'h0093_4505, mem[4]=32'h4501_00A0 -> (0x0, 0x00004505, 1), (0x2, 0x00A00093, 0), (0x6, 0x00004501, 1).
- Spanning wait: head_pc 0x2 with 32-bit halfword, mem[4] delayed 5 cycles -> out_valid stays 0 until the cycle after mem[4] returns.
- Backpressure: out_ready=0, 1-cycle memory -> exactly DEPTH=4 requests (0x0..0xC), req_valid then low; out_ready=1 -> instructions in order, fetch resumes at 0x10.
- Redirect with 2 in flight: redirect_pc=0x102 -> next 2 responses dropped, next req_addr=0x100, first out_pc=0x102 from mem[0x100][31:16].
- Async reset mid-stream with outstanding=3 -> req_valid, out_valid 0 immediately; after release req_addr=RESET_PC, no stale data output.
